// File: rtl/align_sequencer_pkg.sv
// Shared types and constants for the ALIGN layer sequencer and its counter.
package align_sequencer_pkg;

  localparam int unsigned GROUP_SIZE_DEF             = 8;
  localparam int unsigned LOG_GROUP_SIZE_DEF         = 3;
  localparam int unsigned LOG_MAX_HW_DEF             = 8;
  localparam int unsigned LOG_MAX_ITERS_DEF          = 16;
  localparam int unsigned LOG_MAX_READS_PER_ITER_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_CONFIG,
    ST_RUN,
    ST_DONE
  } seq_state_e;

  // Reads width must hold ceil(H*W/GROUP_SIZE) for maximal H and W.
  function automatic bit reads_width_ok(input int unsigned log_hw,
                                        input int unsigned log_gs,
                                        input int unsigned log_reads);
    return log_reads >= (2 * log_hw - log_gs + 1);
  endfunction

  localparam bit READS_WIDTH_OK = reads_width_ok(LOG_MAX_HW_DEF, LOG_GROUP_SIZE_DEF,
                                                 LOG_MAX_READS_PER_ITER_DEF);

endpackage

// File: rtl/align_seq_counter.sv
// Two-level down counter: reads within an iteration, then iterations; flags the last transfer.
module align_seq_counter #(
  parameter int unsigned READS_W = 16,
  parameter int unsigned ITERS_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               dec_i,
  input  logic [READS_W-1:0] reads_i,
  input  logic [ITERS_W-1:0] iters_i,
  output logic               last_c_o
);

  logic [READS_W-1:0] reads_left_q, reads_left_d;
  logic [ITERS_W-1:0] iters_left_q, iters_left_d;

  // reads_i doubles as the per-iteration reload value, so it must stay stable while counting.
  always_comb begin
    reads_left_d = reads_left_q;
    iters_left_d = iters_left_q;
    if (load_i) begin
      reads_left_d = reads_i;
      iters_left_d = iters_i;
    end else if (dec_i) begin
      if (reads_left_q == READS_W'(1)) begin
        if (iters_left_q == ITERS_W'(1)) begin
          reads_left_d = '0;
          iters_left_d = '0;
        end else begin
          reads_left_d = reads_i;
          iters_left_d = iters_left_q - ITERS_W'(1);
        end
      end else begin
        reads_left_d = reads_left_q - READS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      reads_left_q <= '0;
      iters_left_q <= '0;
    end else begin
      reads_left_q <= reads_left_d;
      iters_left_q <= iters_left_d;
    end
  end

  assign last_c_o = (reads_left_q == READS_W'(1)) && (iters_left_q == ITERS_W'(1));

endmodule

// File: rtl/align_sequencer.sv
// Layer-level controller for ALIGN: accepts descriptors, configures ALIGN, counts transfers to done.
// Optional ALIGN_SEQ_PERF_EN adds perf_cycles/perf_stalls counters.
module align_sequencer
  import align_sequencer_pkg::*;
#(
  parameter int unsigned GROUP_SIZE             = GROUP_SIZE_DEF,
  parameter int unsigned LOG_GROUP_SIZE         = LOG_GROUP_SIZE_DEF,
  parameter int unsigned LOG_MAX_HW             = LOG_MAX_HW_DEF,
  parameter int unsigned LOG_MAX_ITERS          = LOG_MAX_ITERS_DEF,
  parameter int unsigned LOG_MAX_READS_PER_ITER = LOG_MAX_READS_PER_ITER_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [LOG_MAX_HW-1:0]             desc_h,
  input  logic [LOG_MAX_HW-1:0]             desc_w,
  input  logic [LOG_MAX_ITERS-1:0]          desc_iters,
  input  logic                              desc_valid,
  output logic                              desc_avail,
  output logic                              configure,
  output logic [LOG_MAX_ITERS-1:0]          num_iters,
  output logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  input  logic                              xfer,
  output logic                              busy,
  output logic                              done
`ifdef ALIGN_SEQ_PERF_EN
  ,
  output logic [31:0]                       perf_cycles,
  output logic [31:0]                       perf_stalls
`endif
);

  localparam int unsigned PROD_W = 2 * LOG_MAX_HW;
  localparam int unsigned RW     = LOG_MAX_READS_PER_ITER;
  localparam int unsigned IW     = LOG_MAX_ITERS;

  seq_state_e          state_q;
  logic [LOG_MAX_HW-1:0] h_q, w_q;
  logic [IW-1:0]       iters_q;
  logic                desc_avail_q, configure_q, busy_q, done_q;
  logic [IW-1:0]       num_iters_q;
  logic [RW-1:0]       num_reads_q;

  logic [PROD_W-1:0]   product_c;
  logic [PROD_W:0]     rounded_c;
  logic [RW-1:0]       reads_c;
  logic                last_c, load_c, dec_c;

  // ceil(H*W / GROUP_SIZE); the extra bit keeps the rounding add from wrapping.
  assign product_c = PROD_W'(h_q) * PROD_W'(w_q);
  assign rounded_c = (PROD_W + 1)'(product_c) + (PROD_W + 1)'(GROUP_SIZE - 1);
  assign reads_c   = RW'(rounded_c >> LOG_GROUP_SIZE);

  assign load_c = (state_q == ST_CONFIG);
  assign dec_c  = (state_q == ST_RUN) && xfer;

  align_seq_counter #(
    .READS_W (RW),
    .ITERS_W (IW)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_c),
    .dec_i    (dec_c),
    .reads_i  (num_reads_q),
    .iters_i  (num_iters_q),
    .last_c_o (last_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      h_q          <= '0;
      w_q          <= '0;
      iters_q      <= '0;
      desc_avail_q <= 1'b0;
      configure_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      num_iters_q  <= '0;
      num_reads_q  <= '0;
    end else begin
      configure_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (desc_valid && desc_avail_q) begin
            h_q          <= desc_h;
            w_q          <= desc_w;
            iters_q      <= desc_iters;
            desc_avail_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= ST_CALC;
          end else begin
            desc_avail_q <= 1'b1;
          end
        end
        ST_CALC: begin
          // Empty layers complete without ever touching ALIGN.
          if ((iters_q == '0) || (reads_c == '0)) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            configure_q <= 1'b1;
            num_iters_q <= iters_q;
            num_reads_q <= reads_c;
            state_q     <= ST_CONFIG;
          end
        end
        ST_CONFIG: state_q <= ST_RUN;
        ST_RUN: begin
          if (xfer && last_c) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          desc_avail_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign desc_avail         = desc_avail_q;
  assign configure          = configure_q;
  assign num_iters          = num_iters_q;
  assign num_reads_per_iter = num_reads_q;
  assign busy               = busy_q;
  assign done               = done_q;

`ifdef ALIGN_SEQ_PERF_EN
  logic [31:0] run_cycles_q, perf_cycles_q, perf_stalls_q;

  // run_cycles_q counts from the CONFIG cycle; the final xfer cycle is added when latching.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_cycles_q  <= '0;
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (state_q == ST_CONFIG) begin
      run_cycles_q  <= 32'd1;
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (state_q == ST_RUN) begin
      run_cycles_q <= run_cycles_q + 32'd1;
      if (!xfer) perf_stalls_q <= perf_stalls_q + 32'd1;
      if (xfer && last_c) perf_cycles_q <= run_cycles_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_align_sequencer.sv
// Self-checking bench for align_sequencer: descriptor table plus hand-written corner sequences.
module tb_align_sequencer;

  localparam int unsigned HW = 8;
  localparam int unsigned IW = 16;
  localparam int unsigned RW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [HW-1:0] desc_h = '0;
  logic [HW-1:0] desc_w = '0;
  logic [IW-1:0] desc_iters = '0;
  logic          desc_valid = 1'b0;
  logic          desc_avail;
  logic          configure;
  logic [IW-1:0] num_iters;
  logic [RW-1:0] num_reads_per_iter;
  logic          xfer = 1'b0;
  logic          busy;
  logic          done;
`ifdef ALIGN_SEQ_PERF_EN
  logic [31:0]   perf_cycles;
  logic [31:0]   perf_stalls;
`endif

  align_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .desc_h             (desc_h),
    .desc_w             (desc_w),
    .desc_iters         (desc_iters),
    .desc_valid         (desc_valid),
    .desc_avail         (desc_avail),
    .configure          (configure),
    .num_iters          (num_iters),
    .num_reads_per_iter (num_reads_per_iter),
    .xfer               (xfer),
    .busy               (busy),
    .done               (done)
`ifdef ALIGN_SEQ_PERF_EN
    ,
    .perf_cycles        (perf_cycles),
    .perf_stalls        (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    int unsigned iters;
    int unsigned reads;
  } cfg_t;
  cfg_t exp_q[$];
  cfg_t mon_e;

  typedef struct {
    int unsigned h;
    int unsigned w;
    int unsigned it;
    int unsigned reads;
    int unsigned gap;
    bit          spur;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every configure pulse must match the oldest expected layer configuration.
  always @(posedge clk) begin
    #2;
    if (done) done_cnt++;
    if (configure) begin
      if (exp_q.size() == 0) begin
        chk("cfg_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("cfg_iters", longint'(num_iters), longint'(mon_e.iters));
        chk("cfg_reads", longint'(num_reads_per_iter), longint'(mon_e.reads));
      end
    end
  end

  task automatic wait_accept(output int t);
    bit got = 1'b0;
    t = cyc;
    for (int i = 0; i < 100; i++) begin
      if (desc_avail && desc_valid) begin
        t = cyc;
        got = 1'b1;
        break;
      end
      step();
    end
    if (!got) chk("accept_timeout", 0, 1);
    step();
  endtask

  task automatic run_xfers(input int n, input int gap);
    bit early = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        if (done) early = 1'b1;
        step();
      end
      if (done) early = 1'b1;
      xfer = 1'b1;
      step();
      xfer = 1'b0;
    end
    chk("no_early_done", longint'(early), 0);
  endtask

  task automatic do_layer(input vec_t v);
    int  t;
    int  n;
    bit  zero;
    zero = (v.it == 0) || (v.reads == 0);
    if (v.spur) begin
      xfer = 1'b1;
      repeat (3) step();
      xfer = 1'b0;
      chk("idle_spur_busy", longint'(busy), 0);
    end
    desc_h = HW'(v.h);
    desc_w = HW'(v.w);
    desc_iters = IW'(v.it);
    desc_valid = 1'b1;
    wait_accept(t);
    desc_valid = 1'b0;
    chk("calc_busy", longint'(busy), 1);
    chk("calc_no_cfg", longint'(configure), 0);
    if (zero) begin
      step();
      chk("zero_done", longint'(done), 1);
      step();
      chk("zero_done_one_cycle", longint'(done), 0);
      chk("zero_avail", longint'(desc_avail), 1);
    end else begin
      exp_q.push_back('{v.it, v.reads});
      if (v.spur) xfer = 1'b1;
      step();
      chk("cfg_pulse", longint'(configure), 1);
      step();
      xfer = 1'b0;
      chk("cfg_one_cycle", longint'(configure), 0);
      n = int'(v.reads * v.it);
      run_xfers(n, int'(v.gap));
      chk("done_pulse", longint'(done), 1);
`ifdef ALIGN_SEQ_PERF_EN
      chk("perf_stalls", longint'(perf_stalls), longint'(n * int'(v.gap)));
      chk("perf_cycles", longint'(perf_cycles), longint'(1 + n * (int'(v.gap) + 1)));
`endif
      step();
      chk("done_one_cycle", longint'(done), 0);
      chk("avail_after_done", longint'(desc_avail), 1);
      chk("cfg_hold_reads", longint'(num_reads_per_iter), longint'(v.reads));
    end
  endtask

  initial begin
    int t1, t2, dc;
    // {h, w, iters, expected reads, gap between xfers, spurious xfers outside RUN}
    vecs[0] = '{3, 3, 2, 2, 0, 1'b0};
    vecs[1] = '{4, 4, 1, 2, 2, 1'b0};
    vecs[2] = '{0, 5, 3, 0, 0, 1'b0};
    vecs[3] = '{1, 1, 1, 1, 0, 1'b0};
    vecs[4] = '{1, 1, 3, 1, 1, 1'b0};
    vecs[5] = '{9, 1, 2, 2, 0, 1'b0};
    vecs[6] = '{17, 1, 1, 3, 1, 1'b0};
    vecs[7] = '{5, 5, 0, 4, 0, 1'b0};
    vecs[8] = '{255, 255, 1, 8129, 0, 1'b1};
    vecs[9] = '{16, 16, 2, 32, 0, 1'b0};

    rst = 1'b0;
    repeat (3) step();
    chk("rst_avail", longint'(desc_avail), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_configure", longint'(configure), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_num_iters", longint'(num_iters), 0);
    chk("rst_num_reads", longint'(num_reads_per_iter), 0);
    rst = 1'b1;
    chk("rst_release_avail", longint'(desc_avail), 0);
    step();
    chk("avail_after_rst", longint'(desc_avail), 1);

    foreach (vecs[i]) do_layer(vecs[i]);

    // Back-to-back descriptors with desc_valid held across the first layer.
    desc_h = 8'd3; desc_w = 8'd3; desc_iters = 16'd1; desc_valid = 1'b1;
    wait_accept(t1);
    desc_h = 8'd8; desc_w = 8'd8; desc_iters = 16'd1;
    exp_q.push_back('{1, 2});
    step();
    chk("b2b_cfg1", longint'(configure), 1);
    step();
    run_xfers(2, 0);
    chk("b2b_done1", longint'(done), 1);
    t1 = cyc;
    wait_accept(t2);
    desc_valid = 1'b0;
    chk("b2b_accept_cycle", longint'(t2 - t1), 1);
    exp_q.push_back('{1, 8});
    step();
    chk("b2b_cfg2", longint'(configure), 1);
    step();
    run_xfers(8, 0);
    chk("b2b_done2", longint'(done), 1);
    step();

    // Reset in the middle of RUN after one of four transfers.
    desc_h = 8'd3; desc_w = 8'd3; desc_iters = 16'd2; desc_valid = 1'b1;
    wait_accept(t1);
    desc_valid = 1'b0;
    exp_q.push_back('{2, 2});
    step();
    step();
    xfer = 1'b1;
    step();
    xfer = 1'b0;
    dc = done_cnt;
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_done", longint'(done), 0);
    chk("midrst_configure", longint'(configure), 0);
    chk("midrst_num_iters", longint'(num_iters), 0);
    chk("midrst_num_reads", longint'(num_reads_per_iter), 0);
    chk("midrst_avail_low", longint'(desc_avail), 0);
    step();
    chk("midrst_avail_high", longint'(desc_avail), 1);
    chk("midrst_no_done_pulse", longint'(done_cnt - dc), 0);
    do_layer(vecs[0]);

    chk("scoreboard_empty", longint'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
